// File: rtl/writeback_if.sv
// Writeback bus bundle: load results (mem_*), ALU results with a ready
// handshake (alu_*), the register-file write port (rf_*) and status outputs
// (pending, wr_count, bad_addr).
// Modports: slave = the writeback unit, master = whatever drives the results
// and observes the write port.
interface writeback_if #(
    parameter int GPR_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 16
);
    logic                      mem_valid;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic [GPR_WIDTH-1:0]      mem_data;
    logic                      alu_valid;
    logic [REG_ADDR_WIDTH-1:0] alu_rd;
    logic [GPR_WIDTH-1:0]      alu_data;
    logic                      alu_ready;
    logic                      rf_en;
    logic [REG_ADDR_WIDTH-1:0] rf_rd;
    logic [GPR_WIDTH-1:0]      rf_data;
    logic [NUM_REGS-1:0]       pending;
    logic [15:0]               wr_count;
    logic                      bad_addr;

    modport slave (
        input  mem_valid, mem_rd, mem_data,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        output rf_en, rf_rd, rf_data,
        output pending, wr_count, bad_addr
    );

    modport master (
        output mem_valid, mem_rd, mem_data,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        input  rf_en, rf_rd, rf_data,
        input  pending, wr_count, bad_addr
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback arbiter: merges load results (never stalled) and ALU results
// (valid/ready) into a single registered register-file write port.
// A one-entry skid buffer parks an ALU result that loses to a load.
// Ports: clk, rst (async, active high), bus (writeback_if.slave).
//
// Skid FSM
//   state      | meaning
//   SKID_EMPTY | no parked ALU result, alu_ready may be 1
//   SKID_FULL  | one ALU result parked, alu_ready = 0
module writeback_unit #(
    parameter int GPR_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 16
) (
    input logic        clk,
    input logic        rst,
    writeback_if.slave bus
);
    localparam logic [0:0] SKID_EMPTY = 1'b0;
    localparam logic [0:0] SKID_FULL  = 1'b1;
    localparam logic [REG_ADDR_WIDTH:0] REG_LIMIT = (REG_ADDR_WIDTH + 1)'(NUM_REGS);

    logic [0:0]                skid_state, skid_state_nxt;
    logic [REG_ADDR_WIDTH-1:0] skid_rd, skid_rd_nxt;
    logic [GPR_WIDTH-1:0]      skid_data, skid_data_nxt;

    logic                      rf_en_q;
    logic [REG_ADDR_WIDTH-1:0] rf_rd_q;
    logic [GPR_WIDTH-1:0]      rf_data_q;
    logic                      bad_q;
    logic [15:0]               count_q;

    logic                      alu_accept;
    logic                      sel_valid;
    logic                      sel_in_range;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [GPR_WIDTH-1:0]      sel_data;
    logic [NUM_REGS-1:0]       pending_c;

    // Ready depends only on the skid register and reset, never on this
    // cycle's inputs, so there is no combinational path valid -> ready.
    assign bus.alu_ready = (skid_state == SKID_EMPTY) && !rst;
    assign alu_accept    = bus.alu_valid && bus.alu_ready;

    // Selection priority: load > parked ALU result > direct ALU result.
    always_comb begin
        skid_state_nxt = skid_state;
        skid_rd_nxt    = skid_rd;
        skid_data_nxt  = skid_data;
        sel_valid      = 1'b0;
        sel_rd         = skid_rd;
        sel_data       = skid_data;
        if (bus.mem_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.mem_rd;
            sel_data  = bus.mem_data;
            if (skid_state == SKID_FULL) begin
                // The load is younger than the parked result to the same
                // register, so the parked value would only be overwritten.
                if (skid_rd == bus.mem_rd) begin
                    skid_state_nxt = SKID_EMPTY;
                end
            end else if (alu_accept) begin
                skid_state_nxt = SKID_FULL;
                skid_rd_nxt    = bus.alu_rd;
                skid_data_nxt  = bus.alu_data;
            end
        end else if (skid_state == SKID_FULL) begin
            sel_valid      = 1'b1;
            skid_state_nxt = SKID_EMPTY;
        end else if (alu_accept) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end
    end

    assign sel_in_range = {1'b0, sel_rd} < REG_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_state <= SKID_EMPTY;
            skid_rd    <= '0;
            skid_data  <= '0;
        end else begin
            skid_state <= skid_state_nxt;
            skid_rd    <= skid_rd_nxt;
            skid_data  <= skid_data_nxt;
        end
    end

    // Out-of-range writes complete their handshake but only raise bad_addr;
    // rf_rd/rf_data keep the last real write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            bad_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            rf_en_q <= sel_valid && sel_in_range;
            bad_q   <= sel_valid && !sel_in_range;
            if (sel_valid && sel_in_range) begin
                rf_rd_q   <= sel_rd;
                rf_data_q <= sel_data;
                count_q   <= count_q + 16'd1;
            end
        end
    end

    // Indices >= NUM_REGS match no loop value and so set no bit.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if ((skid_state == SKID_FULL && skid_rd == REG_ADDR_WIDTH'(i)) ||
                (rf_en_q && rf_rd_q == REG_ADDR_WIDTH'(i))) begin
                pending_c[i] = 1'b1;
            end
        end
    end

    assign bus.rf_en    = rf_en_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_data  = rf_data_q;
    assign bus.bad_addr = bad_q;
    assign bus.wr_count = count_q;
    assign bus.pending  = pending_c;
endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
    localparam int GW = 32;
    localparam int AW = 5;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_if #(.GPR_WIDTH(GW), .REG_ADDR_WIDTH(AW), .NUM_REGS(NR)) bus ();

    writeback_unit #(.GPR_WIDTH(GW), .REG_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [GW-1:0] data;
    } wr_t;

    // Reference model: a queue of at most one parked write plus the
    // expected contents of the write port.
    wr_t           skid_q[$];
    logic          m_en;
    logic          m_bad;
    logic [AW-1:0] m_rd;
    logic [GW-1:0] m_data;
    logic [15:0]   m_count;
    logic [NR-1:0] m_pending;

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        skid_q.delete();
        m_en = 0; m_bad = 0; m_rd = '0; m_data = '0; m_count = '0; m_pending = '0;
    endtask

    task automatic model_step(input bit mv, input logic [AW-1:0] mrd, input logic [GW-1:0] md,
                              input bit av, input logic [AW-1:0] ard, input logic [GW-1:0] ad);
        bit  acc  = av && (skid_q.size() == 0);
        bit  have = 0;
        wr_t s;
        if (mv) begin
            s = '{mrd, md}; have = 1;
            if (skid_q.size() != 0 && skid_q[0].rd == mrd) skid_q.delete();
            else if (skid_q.size() == 0 && acc) skid_q.push_back('{ard, ad});
        end else if (skid_q.size() != 0) begin
            s = skid_q.pop_front(); have = 1;
        end else if (acc) begin
            s = '{ard, ad}; have = 1;
        end
        m_bad = have && (int'(s.rd) >= NR);
        m_en  = have && (int'(s.rd) < NR);
        if (m_en) begin
            m_rd = s.rd; m_data = s.data; m_count = m_count + 16'd1;
        end
        m_pending = '0;
        if (m_en) m_pending[m_rd] = 1'b1;
        if (skid_q.size() != 0 && int'(skid_q[0].rd) < NR) m_pending[skid_q[0].rd] = 1'b1;
    endtask

    task automatic set_in(input bit mv, input logic [AW-1:0] mrd, input logic [GW-1:0] md,
                          input bit av, input logic [AW-1:0] ard, input logic [GW-1:0] ad);
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        bit            mv  = bus.mem_valid;
        logic [AW-1:0] mrd = bus.mem_rd;
        logic [GW-1:0] md  = bus.mem_data;
        bit            av  = bus.alu_valid;
        logic [AW-1:0] ard = bus.alu_rd;
        logic [GW-1:0] ad  = bus.alu_data;
        @(posedge clk);
        #1;
        model_step(mv, mrd, md, av, ard, ad);
    endtask

    task automatic do_reset();
        set_in(0, '0, '0, 0, '0, '0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, '0, '0, 0, '0, '0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.alu_ready); end
        total++; if (bus.rf_en !== 1'b0) begin bad++; $display("FAIL reset_rf_en got=%b want=0", bus.rf_en); end
        total++; if (bus.rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd got=%0d want=0", bus.rf_rd); end
        total++; if (bus.rf_data !== 32'd0) begin bad++; $display("FAIL reset_rf_data got=%h want=0", bus.rf_data); end
        total++; if (bus.pending !== 16'd0) begin bad++; $display("FAIL reset_pending got=%h want=0", bus.pending); end
        total++; if (bus.wr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.wr_count); end
        total++; if (bus.bad_addr !== 1'b0) begin bad++; $display("FAIL reset_bad got=%b want=0", bus.bad_addr); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu_alone();
        do_reset();
        set_in(0, '0, '0, 1, 5'd3, 32'hA5A5A5A5);
        cycle();
        set_in(0, '0, '0, 0, '0, '0);
        total++; if (bus.rf_en !== 1'b1) begin bad++; $display("FAIL alu_rf_en got=%b want=1", bus.rf_en); end
        total++; if (bus.rf_rd !== 5'd3) begin bad++; $display("FAIL alu_rf_rd got=%0d want=3", bus.rf_rd); end
        total++; if (bus.rf_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL alu_rf_data got=%h want=a5a5a5a5", bus.rf_data); end
        total++; if (bus.pending !== 16'h0008) begin bad++; $display("FAIL alu_pending got=%h want=0008", bus.pending); end
        total++; if (bus.wr_count !== 16'd1) begin bad++; $display("FAIL alu_count got=%0d want=1", bus.wr_count); end
    endtask

    task automatic test_collision();
        do_reset();
        set_in(1, 5'd2, 32'h11, 1, 5'd5, 32'h22);
        cycle();
        set_in(0, '0, '0, 0, '0, '0);
        total++; if (bus.rf_en !== 1'b1 || bus.rf_rd !== 5'd2 || bus.rf_data !== 32'h11) begin
            bad++; $display("FAIL coll_c1 got en=%b rd=%0d data=%h want en=1 rd=2 data=11", bus.rf_en, bus.rf_rd, bus.rf_data); end
        total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL coll_c1_ready got=%b want=0", bus.alu_ready); end
        total++; if (bus.pending !== 16'h0024) begin bad++; $display("FAIL coll_c1_pending got=%h want=0024", bus.pending); end
        cycle();
        total++; if (bus.rf_en !== 1'b1 || bus.rf_rd !== 5'd5 || bus.rf_data !== 32'h22) begin
            bad++; $display("FAIL coll_c2 got en=%b rd=%0d data=%h want en=1 rd=5 data=22", bus.rf_en, bus.rf_rd, bus.rf_data); end
        cycle();
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL coll_c3_ready got=%b want=1", bus.alu_ready); end
        total++; if (bus.rf_en !== 1'b0 || bus.wr_count !== 16'd2) begin
            bad++; $display("FAIL coll_c3 got en=%b count=%0d want en=0 count=2", bus.rf_en, bus.wr_count); end
    endtask

    task automatic test_discard();
        do_reset();
        set_in(1, 5'd1, 32'h55, 1, 5'd7, 32'h33);
        cycle();
        total++; if (bus.pending !== 16'h0082) begin bad++; $display("FAIL disc_c1_pending got=%h want=0082", bus.pending); end
        set_in(1, 5'd7, 32'h44, 1, 5'd9, 32'h99);
        cycle();
        set_in(0, '0, '0, 0, '0, '0);
        total++; if (bus.rf_en !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_data !== 32'h44) begin
            bad++; $display("FAIL disc_c2 got en=%b rd=%0d data=%h want en=1 rd=7 data=44", bus.rf_en, bus.rf_rd, bus.rf_data); end
        total++; if (bus.alu_ready !== 1'b1 || bus.pending !== 16'h0080) begin
            bad++; $display("FAIL disc_c2_skid got ready=%b pending=%h want ready=1 pending=0080", bus.alu_ready, bus.pending); end
        total++; if (bus.wr_count !== 16'd2) begin bad++; $display("FAIL disc_c2_count got=%0d want=2", bus.wr_count); end
        cycle();
        total++; if (bus.rf_en !== 1'b0 || bus.wr_count !== 16'd2) begin
            bad++; $display("FAIL disc_c3 got en=%b count=%0d want en=0 count=2", bus.rf_en, bus.wr_count); end
    endtask

    task automatic test_bad_index();
        do_reset();
        set_in(0, '0, '0, 1, 5'd20, 32'hDEAD);
        cycle();
        set_in(0, '0, '0, 0, '0, '0);
        total++; if (bus.rf_en !== 1'b0 || bus.bad_addr !== 1'b1) begin
            bad++; $display("FAIL bad_c1 got en=%b bad_addr=%b want en=0 bad_addr=1", bus.rf_en, bus.bad_addr); end
        total++; if (bus.wr_count !== 16'd0 || bus.pending !== 16'd0) begin
            bad++; $display("FAIL bad_c1_state got count=%0d pending=%h want 0 0", bus.wr_count, bus.pending); end
        cycle();
        total++; if (bus.bad_addr !== 1'b0) begin bad++; $display("FAIL bad_c2_pulse got=%b want=0", bus.bad_addr); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_in(1, 5'd2, 32'h11, 1, 5'd5, 32'h22);
        cycle();
        set_in(0, '0, '0, 0, '0, '0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (bus.rf_en !== 1'b0 || bus.pending !== 16'd0 || bus.alu_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid got en=%b pending=%h ready=%b want 0 0 0", bus.rf_en, bus.pending, bus.alu_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%b want=1", bus.alu_ready); end
        total++; if (bus.rf_en !== 1'b0 || bus.pending !== 16'd0 || bus.wr_count !== 16'd0) begin
            bad++; $display("FAIL rst_rel got en=%b pending=%h count=%0d want 0 0 0", bus.rf_en, bus.pending, bus.wr_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 9) < 4, 5'($urandom_range(0, 19)), $urandom,
                   $urandom_range(0, 9) < 6, 5'($urandom_range(0, 19)), $urandom);
            #1;
            total++; if (bus.alu_ready !== (skid_q.size() == 0)) begin
                bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, bus.alu_ready, skid_q.size() == 0); end
            cycle();
            total++; if (bus.rf_en !== m_en || bus.rf_rd !== m_rd || bus.rf_data !== m_data) begin
                bad++; $display("FAIL rnd_port n=%0d got en=%b rd=%0d data=%h want en=%b rd=%0d data=%h",
                                n, bus.rf_en, bus.rf_rd, bus.rf_data, m_en, m_rd, m_data); end
            total++; if (bus.bad_addr !== m_bad || bus.pending !== m_pending || bus.wr_count !== m_count) begin
                bad++; $display("FAIL rnd_status n=%0d got bad=%b pend=%h cnt=%0d want bad=%b pend=%h cnt=%0d",
                                n, bus.bad_addr, bus.pending, bus.wr_count, m_bad, m_pending, m_count); end
        end
        set_in(0, '0, '0, 0, '0, '0);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 65536; n++) begin
            set_in(0, '0, '0, 1, 5'(n % 16), 32'(n));
            cycle();
            if (n == 65534) begin
                total++; if (bus.wr_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", bus.wr_count); end
            end
        end
        set_in(0, '0, '0, 0, '0, '0);
        total++; if (bus.wr_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", bus.wr_count); end
        total++; if (bus.wr_count !== m_count) begin bad++; $display("FAIL wrap_model got=%h want=%h", bus.wr_count, m_count); end
    endtask

    initial begin
        set_in(0, '0, '0, 0, '0, '0);
        test_reset();
        test_alu_alone();
        test_collision();
        test_discard();
        test_bad_index();
        test_reset_mid_stall();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
